nibble_serial_subtractor: RTL and testbench
===========================================

# nibble_serial_subtractor

Multi-cycle 16-bit subtractor for the ALU datapath that computes op1 − op2 − b_in one 4-bit slice per clock, LSB slice first, carrying the borrow in a register between slices. Each slice uses borrow-select: two candidate differences for borrow-in 0 and 1, chosen by the registered borrow. Operands enter through a valid/ready handshake, and the difference plus flags leave through a second one. Its borrow-out chains into a wider operation.

## Interface
- W, 16, operand/result width; must be a multiple of SLICE_W
- SLICE_W, 4, bits processed per cycle; N_SLICES = W/SLICE_W
- clk  input  1  single clock; all state changes on its rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  op1/op2/b_in valid
- in_ready  output  1  block accepts a new operation (high only in IDLE)
- op1  input  W  minuend, two's complement
- op2  input  W  subtrahend, two's complement
- b_in  input  1  borrow-in; 1 subtracts an additional 1
- out_valid  output  1  result and flags valid
- out_ready  input  1  consumer accepts result
- result  output  W  op1 − op2 − b_in, modulo 2^W
- b_out  output  1  unsigned borrow-out (1 when op1 < op2 + b_in, unsigned)
- zero  output  1  result == 0
- negative  output  1  result[W−1]
- overflow  output  1  signed overflow

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready = 1. On in_valid, capture op1, op2, b_in into operand registers, load the borrow register with b_in, and clear the slice counter. Next state RUN.
- RUN: in_ready = 0. For slice k (the counter), diff0 = a_k − b_k and diff1 = a_k − b_k − 1, each with its own borrow-out. The registered borrow selects the pair. The selected difference is written to result bits [k*SLICE_W +: SLICE_W], and the selected borrow goes into the borrow register. The counter increments.
- When k = N_SLICES−1, transition to DONE and latch the flags from the final values.
- DONE: out_valid = 1. result, b_out and flags are held stable. On out_ready, go to IDLE and drop out_valid.
- Flag rules:
  - b_out = final borrow register.
  - overflow = (op1[W−1] ≠ op2[W−1]) && (result[W−1] ≠ op1[W−1]).
  - zero and negative come from the full result.
- in_valid is ignored outside IDLE. Operands captured in IDLE are not affected by later input changes.
- Any reset assertion, including mid-RUN or in DONE, aborts the operation. The block returns to IDLE with no partial result emitted.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, result 0, b_out 0, zero 0, negative 0, overflow 0, counter 0, borrow 0.
- Accept edge N (in_valid && in_ready) → RUN slices occupy cycles N+1 … N+N_SLICES → out_valid high from edge N+N_SLICES (4 cycles after acceptance at defaults).
- The result register changes one slice per RUN cycle. Outputs are only meaningful while out_valid = 1.
- If out_valid && out_ready at edge M, then IDLE follows with in_ready = 1 after M, so the next accept is earliest at edge M+1.
- Minimum issue interval at defaults with out_ready held high: 6 cycles.
- Backpressure: out_ready may stay low indefinitely. All outputs are frozen and in_ready stays 0.
- No combinational path from in_valid or out_ready to any output. in_ready and out_valid decode from registered state only.

## Structure
- Shared package alu_pkg holds:
  - the state enum {IDLE, RUN, DONE};
  - SLICE_W and N_SLICES constants;
  - the counter width $clog2(N_SLICES).
- Sub-module borrow_select_slice (SLICE_W-bit) contains:
  - two ripple subtractors with borrow-in tied to 0 and 1;
  - a 2:1 mux selecting difference and borrow by the incoming borrow.
- The top level contains the FSM, operand/result/borrow registers, slice counter, slice muxing and flag logic.

## Test plan
- 0x1234 − 0x0234, b_in 0 → result 0x1000, b_out 0, zero 0, negative 0, overflow 0; out_valid exactly 4 cycles after the accept edge.
- 0x0000 − 0x0001, b_in 0 → 0xFFFF, b_out 1, negative 1, overflow 0. This checks the borrow ripples across all 4 slices.
- 0x8000 − 0x0001 → 0x7FFF, overflow 1, b_out 0. Then 0x7FFF − 0xFFFF → 0x8000, overflow 1, b_out 1.
- 0x5A5A − 0x5A59, b_in 1 → 0x0000, zero 1, b_out 0.
- Result 0x1000 held with out_ready low for 3 cycles:
  - outputs stay stable, in_ready 0, and in_valid pulses are ignored;
  - out_ready high → out_valid 0 and in_ready 1 next cycle;
  - back-to-back accept succeeds.
- Reset asserted during the second RUN cycle → outputs immediately take reset values and no out_valid appears. After deassert, a fresh 0x0003 − 0x0001 returns 0x0002.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer states and slice geometry for the
// nibble-serial subtractor.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SLICE_W  = 4;
  localparam int N_SLICES = 16 / SLICE_W;
  localparam int CNT_W    = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;

endpackage

// File: rtl/borrow_select_slice.sv
// One SLICE_W-bit subtract slice. Both borrow-in candidates are computed up
// front so the late-arriving borrow only drives a 2:1 mux.
module borrow_select_slice #(
  parameter int SLICE_W = 4
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               borrow_in,
  output logic [SLICE_W-1:0] diff,
  output logic               borrow_out
);

  // Bit-level ripple subtractor; returns {borrow_out, difference}.
  function automatic logic [SLICE_W:0] ripple_sub(
    input logic [SLICE_W-1:0] x,
    input logic [SLICE_W-1:0] y,
    input logic               bin
  );
    logic [SLICE_W-1:0] d;
    logic               br;
    br = bin;
    for (int i = 0; i < SLICE_W; i++) begin
      d[i] = x[i] ^ y[i] ^ br;
      br   = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br);
    end
    return {br, d};
  endfunction

  logic [SLICE_W-1:0] diff0;
  logic [SLICE_W-1:0] diff1;
  logic               bo0;
  logic               bo1;

  assign {bo0, diff0} = ripple_sub(a, b, 1'b0);
  assign {bo1, diff1} = ripple_sub(a, b, 1'b1);

  // Incoming borrow picks the matching candidate pair.
  always_comb begin
    diff       = borrow_in ? diff1 : diff0;
    borrow_out = borrow_in ? bo1   : bo0;
  end

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle W-bit subtractor: op1 - op2 - b_in, one slice per clock,
// LSB slice first, with the borrow carried in a register between slices.
module nibble_serial_subtractor
  import alu_pkg::*;
#(
  parameter int W       = 16,
  parameter int SLICE_W = alu_pkg::SLICE_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op1,
  input  logic [W-1:0] op2,
  input  logic         b_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         b_out,
  output logic         zero,
  output logic         negative,
  output logic         overflow
);

  localparam int NS = W / SLICE_W;
  localparam int CW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NS - 1);

  state_t             state;
  logic [W-1:0]       op1_q;
  logic [W-1:0]       op2_q;
  logic               borrow;
  logic [CW-1:0]      cnt;

  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_diff;
  logic               slice_borrow;
  logic [W-1:0]       result_next;

  // Current slice of each captured operand, and the result with it merged in.
  always_comb begin
    slice_a     = op1_q[int'(cnt)*SLICE_W +: SLICE_W];
    slice_b     = op2_q[int'(cnt)*SLICE_W +: SLICE_W];
    result_next = result;
    result_next[int'(cnt)*SLICE_W +: SLICE_W] = slice_diff;
  end

  borrow_select_slice #(
    .SLICE_W(SLICE_W)
  ) u_slice (
    .a         (slice_a),
    .b         (slice_b),
    .borrow_in (borrow),
    .diff      (slice_diff),
    .borrow_out(slice_borrow)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Sequencer: capture in IDLE, one slice per RUN cycle, hold in DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      op1_q    <= '0;
      op2_q    <= '0;
      borrow   <= 1'b0;
      cnt      <= '0;
      result   <= '0;
      b_out    <= 1'b0;
      zero     <= 1'b0;
      negative <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op1_q  <= op1;
            op2_q  <= op2;
            borrow <= b_in;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          result <= result_next;
          borrow <= slice_borrow;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            b_out    <= slice_borrow;
            zero     <= (result_next == '0);
            negative <= result_next[W-1];
            overflow <= (op1_q[W-1] != op2_q[W-1]) &&
                        (result_next[W-1] != op1_q[W-1]);
            state    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed bench for nibble_serial_subtractor with hand-computed vectors.
module tb_nibble_serial_subtractor;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] op1;
  logic [15:0] op2;
  logic        b_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        b_out;
  logic        zero;
  logic        negative;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int lat;

  always #5 clk = ~clk;

  nibble_serial_subtractor dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op1      (op1),
    .op2      (op2),
    .b_in     (b_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .b_out    (b_out),
    .zero     (zero),
    .negative (negative),
    .overflow (overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string tag, input logic [15:0] r,
                           input logic bo, input logic z, input logic n, input logic o);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_result"}, {16'd0, result}, {16'd0, r});
    check({tag, "_flags"}, {28'd0, b_out, zero, negative, overflow},
          {28'd0, bo, z, n, o});
  endtask

  // Present an operation, wait for acceptance, scramble inputs afterwards,
  // then count cycles until out_valid.
  task automatic start(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic bi);
    int t;
    t = 0;
    while (!in_ready && t < 20) begin
      @(posedge clk); #1; t++;
    end
    check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    op1 = a; op2 = b; b_in = bi; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op1 = 16'hDEAD; op2 = 16'hBEEF; b_in = 1'b1;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic finish_op(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_drop"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op1 = '0; op2 = '0; b_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ctrl", {30'd0, in_ready, out_valid}, 32'd2);
    check("reset_data", {12'd0, result, b_out, zero, negative, overflow}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    start("v1", 16'h1234, 16'h0234, 1'b0);
    check("v1_latency", lat, 32'd4);
    check_res("v1", 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
    finish_op("v1");

    start("v2", 16'h0000, 16'h0001, 1'b0);
    check_res("v2", 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    finish_op("v2");

    start("v3", 16'h8000, 16'h0001, 1'b0);
    check_res("v3", 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1);
    finish_op("v3");

    start("v4", 16'h7FFF, 16'hFFFF, 1'b0);
    check_res("v4", 16'h8000, 1'b1, 1'b0, 1'b1, 1'b1);
    finish_op("v4");

    start("v5", 16'h5A5A, 16'h5A59, 1'b1);
    check_res("v5", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    finish_op("v5");

    // Backpressure: hold the result while in_valid pulses are offered.
    start("bp", 16'h1234, 16'h0234, 1'b0);
    for (int i = 0; i < 3; i++) begin
      op1 = 16'h0F0F; op2 = 16'h0101; in_valid = (i != 1);
      @(posedge clk); #1;
      check_res("bp_hold", 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    finish_op("bp");

    // Back-to-back accept right after the handshake.
    start("b2b", 16'h00FF, 16'h000F, 1'b0);
    check("b2b_latency", lat, 32'd4);
    check_res("b2b", 16'h00F0, 1'b0, 1'b0, 1'b0, 1'b0);
    finish_op("b2b");

    // Abort in the second RUN cycle.
    op1 = 16'h1111; op2 = 16'h0001; b_in = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("abort_ctrl", {30'd0, in_ready, out_valid}, 32'd2);
    check("abort_data", {12'd0, result, b_out, zero, negative, overflow}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
        @(posedge clk); #1;
        if (out_valid) seen++;
      end
      check("abort_no_valid", seen, 32'd0);
    end

    start("post", 16'h0003, 16'h0001, 1'b0);
    check("post_latency", lat, 32'd4);
    check_res("post", 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
    finish_op("post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
